// File: rtl/background3_scroller.sv
// background3_scroller
// Turns the VGA draw position into a horizontally scrolling address into the
// 4-bit-index background3 image ROM, and hands the fetched colour index to the
// palette stage with a fixed 3-cycle latency from the sampling clock edge.
// The scroll offset steps once per frame while the game runs and wraps at
// IMG_W, so the image tiles seamlessly.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | at start position, scroll_x held at 0, waiting for run
// RUN   | game running, scroll_x advances by speed on every frame_start
// HOLD  | game paused, scroll_x frozen until run returns
module background3_scroller #(
  parameter int          IMG_W       = 320,
  parameter int          IMG_H       = 240,
  parameter int          SCALE_SHIFT = 1,
  parameter int          ADDR_W      = 17,
  parameter logic [3:0]  FILL_INDEX  = 4'h3
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic              run,
  input  logic              restart,
  input  logic [3:0]        speed,
  input  logic              pix_valid,
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_q,
  output logic [3:0]        index_out,
  output logic              index_valid,
  output logic [8:0]        scroll_x,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_e;

  localparam logic [9:0]  IMG_W_10   = 10'(IMG_W);
  localparam logic [10:0] IMG_W_11   = 11'(IMG_W);
  localparam logic [9:0]  IMG_H_10   = 10'(IMG_H);
  localparam logic [31:0] IMG_W_BITS = 32'(IMG_W);

  state_e              state_q;
  logic [8:0]          scroll_q;
  logic [9:0]          scroll_sum;
  logic [8:0]          scroll_d;

  // stage 1: downscaled coordinates
  logic                v1_q;
  logic [9:0]          sx_q;
  logic [9:0]          sy_q;

  // column / row address arithmetic feeding stage 2
  logic [10:0]         col_sum;
  logic [10:0]         col;
  logic [ADDR_W-1:0]   row_base;
  logic [ADDR_W-1:0]   addr_d;

  // stage 2: ROM address out, row range flag
  logic                v2_q;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic                oor2_q;

  // stage 3: ROM data in flight
  logic                v3_q;
  logic                oor3_q;

  // stage 4: palette-facing outputs
  logic [3:0]          index_out_q;
  logic                index_valid_q;

  // Next scroll offset: one conditional subtract is enough because both
  // scroll_q and speed are below IMG_W.
  always_comb begin
    scroll_sum = {1'b0, scroll_q} + 10'(speed);
    scroll_d   = 9'((scroll_sum >= IMG_W_10) ? (scroll_sum - IMG_W_10) : scroll_sum);
  end

  // Frame-level sequencer; restart overrides everything, other moves only on frame_start.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      scroll_q <= '0;
    end else if (restart) begin
      state_q  <= ST_IDLE;
      scroll_q <= '0;
    end else if (frame_start) begin
      case (state_q)
        ST_IDLE: begin
          if (run) state_q <= ST_RUN;
        end
        ST_RUN: begin
          scroll_q <= scroll_d;
          if (!run) state_q <= ST_HOLD;
        end
        ST_HOLD: begin
          if (run) state_q <= ST_RUN;
        end
        default: begin
          state_q  <= ST_IDLE;
          scroll_q <= '0;
        end
      endcase
    end
  end

  // Stage 1: capture the draw position scaled down to image pixels.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      v1_q <= 1'b0;
      sx_q <= '0;
      sy_q <= '0;
    end else begin
      v1_q <= pix_valid;
      sx_q <= draw_x >> SCALE_SHIFT;
      sy_q <= draw_y >> SCALE_SHIFT;
    end
  end

  // Scrolled column with a single wrap, and row*IMG_W built as a sum of
  // shifted copies of the row, one per set bit of the constant width.
  always_comb begin
    col_sum  = 11'(sx_q) + 11'(scroll_q);
    col      = (col_sum >= IMG_W_11) ? (col_sum - IMG_W_11) : col_sum;
    row_base = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (IMG_W_BITS[i]) row_base = row_base + (ADDR_W'(sy_q) << i);
    end
    addr_d   = row_base + ADDR_W'(col);
  end

  // Stage 2: register the ROM address and note rows below the image.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      v2_q       <= 1'b0;
      rom_addr_q <= '0;
      oor2_q     <= 1'b0;
    end else begin
      v2_q       <= v1_q;
      rom_addr_q <= addr_d;
      oor2_q     <= (sy_q >= IMG_H_10);
    end
  end

  // Stage 3: carry valid and range flag while the ROM performs its read.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      v3_q   <= 1'b0;
      oor3_q <= 1'b0;
    end else begin
      v3_q   <= v2_q;
      oor3_q <= oor2_q;
    end
  end

  // Stage 4: select fill or ROM data; an empty slot keeps the last index.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      index_out_q   <= FILL_INDEX;
      index_valid_q <= 1'b0;
    end else begin
      index_valid_q <= v3_q;
      if (v3_q) index_out_q <= oor3_q ? FILL_INDEX : rom_q;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign index_out   = index_out_q;
  assign index_valid = index_valid_q;
  assign scroll_x    = scroll_q;
  assign state       = state_q;

endmodule

// File: tb/tb_background3_scroller.sv
// Directed bench for background3_scroller: a frame-level model of the
// sequencer and a per-pixel scoreboard of expected colour indices.
module tb_background3_scroller;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic        run;
  logic        restart;
  logic [3:0]  speed;
  logic        pix_valid;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [16:0] rom_addr;
  logic [3:0]  rom_q;
  logic [3:0]  index_out;
  logic        index_valid;
  logic [8:0]  scroll_x;
  logic [1:0]  state;

  background3_scroller dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .run         (run),
    .restart     (restart),
    .speed       (speed),
    .pix_valid   (pix_valid),
    .draw_x      (draw_x),
    .draw_y      (draw_y),
    .rom_addr    (rom_addr),
    .rom_q       (rom_q),
    .index_out   (index_out),
    .index_valid (index_valid),
    .scroll_x    (scroll_x),
    .state       (state)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM whose data is the low nibble of its address.
  always @(posedge Clk) rom_q <= rom_addr[3:0];

  typedef struct {
    logic [3:0] idx;
    int         due;
  } exp_t;

  exp_t       sb[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         m_state  = 0;
  int         m_scroll = 0;
  logic [3:0] last_idx = 4'h3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] exp_addr(input int x, input int y, input int s);
    int col;
    col = (x >> 1) + s;
    if (col >= 320) col = col - 320;
    return 17'((((y >> 1) * 320) + col) % 131072);
  endfunction

  function automatic logic [3:0] exp_idx(input int x, input int y, input int s);
    logic [16:0] a;
    a = exp_addr(x, y, s);
    if ((y >> 1) >= 240) return 4'h3;
    return a[3:0];
  endfunction

  // One clock; afterwards compare any delivered index against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge Clk);
    #1;
    cyc++;
    if (index_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(index_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("index_out", 32'(index_out), 32'(e.idx));
        chk("index_latency", cyc, e.due);
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      chk("index_valid", 32'(index_valid), 32'd1);
      void'(sb.pop_front());
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present one pixel for a single cycle and record its expected index.
  task automatic pix(input int x, input int y);
    exp_t e;
    pix_valid = 1'b1;
    draw_x    = 10'(x);
    draw_y    = 10'(y);
    e.idx     = exp_idx(x, y, m_scroll);
    e.due     = cyc + 4;
    sb.push_back(e);
    last_idx  = e.idx;
    tick();
    pix_valid = 1'b0;
  endtask

  // Single pixel whose ROM address is inspected one clock after sampling.
  task automatic pix_addr(input int x, input int y);
    logic [16:0] a;
    a = exp_addr(x, y, m_scroll);
    pix(x, y);
    tick();
    chk("rom_addr", 32'(rom_addr), 32'(a));
  endtask

  // One frame_start pulse with run/restart, then check state and scroll.
  task automatic frame(input logic r, input logic rs);
    frame_start = 1'b1;
    run         = r;
    restart     = rs;
    if (rs) begin
      m_state  = 0;
      m_scroll = 0;
    end else begin
      case (m_state)
        0: if (r) m_state = 1;
        1: begin
          m_scroll = m_scroll + int'(speed);
          if (m_scroll >= 320) m_scroll = m_scroll - 320;
          if (!r) m_state = 2;
        end
        2: if (r) m_state = 1;
        default: m_state = 0;
      endcase
    end
    tick();
    frame_start = 1'b0;
    restart     = 1'b0;
    chk("state", 32'(state), m_state);
    chk("scroll_x", 32'(scroll_x), m_scroll);
  endtask

  initial begin
    Reset       = 1'b1;
    frame_start = 1'b0;
    run         = 1'b0;
    restart     = 1'b0;
    speed       = 4'd0;
    pix_valid   = 1'b0;
    draw_x      = '0;
    draw_y      = '0;
    idle(2);
    Reset = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_scroll", 32'(scroll_x), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_index_out", 32'(index_out), 32'h3);
    chk("rst_index_valid", 32'(index_valid), 32'd0);

    // First pixel at the origin, then an addressed pixel and a random burst.
    pix(0, 0);
    idle(4);
    pix_addr(100, 50);
    idle(3);
    for (int i = 0; i < 8; i++) pix($urandom_range(0, 639), $urandom_range(0, 479));
    idle(4);
    idle(2);
    chk("index_hold", 32'(index_out), 32'(last_idx));

    // Leave IDLE, then four scrolling frames at speed 5.
    speed = 4'd5;
    frame(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) frame(1'b1, 1'b0);
    run = 1'b0;
    idle(2);
    chk("no_frame_state", 32'(state), 32'd1);
    chk("no_frame_scroll", 32'(scroll_x), 32'd20);
    run = 1'b1;
    pix(630, 100);
    idle(4);

    // Drive scroll to 318, then step across the wrap.
    frame(1'b1, 1'b1);
    frame(1'b1, 1'b0);
    speed = 4'd15;
    for (int i = 0; i < 21; i++) frame(1'b1, 1'b0);
    speed = 4'd3;
    frame(1'b1, 1'b0);
    speed = 4'd5;
    frame(1'b1, 1'b0);
    pix_addr(638, 200);
    idle(3);
    speed = 4'd0;
    frame(1'b1, 1'b0);

    // Rows below the image emit the fill index regardless of ROM data.
    pix(100, 490);
    pix(10, 1023);
    pix(20, 478);
    idle(4);

    // Pause for three frames, then resume.
    speed = 4'd7;
    frame(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0);
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);

    // Restart beats frame_start; the in-flight pixel keeps the old offset.
    pix(200, 60);
    frame(1'b1, 1'b1);
    idle(4);

    // Reset mid-line drops everything in flight.
    frame(1'b1, 1'b0);
    pix(300, 300);
    pix(301, 300);
    Reset = 1'b1;
    tick();
    sb.delete();
    m_state  = 0;
    m_scroll = 0;
    chk("midrst_index_valid", 32'(index_valid), 32'd0);
    chk("midrst_state", 32'(state), 32'd0);
    Reset = 1'b0;
    idle(6);
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
